// File: rtl/nap_pkg.sv
// Shared state encodings and default timing for the nap scheduler.
// Pure declarations: no logic, no latency, no flow control.
package nap_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_COUNT  = 2'd1;
    localparam logic [1:0] ST_RING   = 2'd2;
    localparam logic [1:0] ST_SNOOZE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_COUNT  = ST_COUNT,
        S_RING   = ST_RING,
        S_SNOOZE = ST_SNOOZE
    } nap_state_t;

    localparam int DEF_TICK_DIV     = 50_000_000;
    localparam int DEF_CNT_W        = 16;
    localparam int DEF_SNOOZE_SEC   = 300;
    localparam int DEF_RING_MAX_SEC = 60;
    localparam int DEF_MAX_SNOOZE   = 3;

endpackage

// File: rtl/nap_sec_ticker.sv
// One-second prescaler: o_tick is high in the last cycle of each TICK_DIV-cycle period.
// Tick is combinational from the count; i_clr restarts the period with no backpressure.
module nap_sec_ticker #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tick = w_last;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/nap_scheduler.sv
// Nap countdown and alarm sequencer; sole start/stop driver of the alarm block.
// All outputs registered (1-cycle latency from inputs); button pulses are never stalled.
module nap_scheduler
    import nap_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int SNOOZE_SEC   = DEF_SNOOZE_SEC,
    parameter int RING_MAX_SEC = DEF_RING_MAX_SEC,
    parameter int MAX_SNOOZE   = DEF_MAX_SNOOZE,
    localparam int SCW         = $clog2(MAX_SNOOZE + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             arm,
    input  logic [CNT_W-1:0] nap_sec,
    input  logic             cancel,
    input  logic             snooze_btn,
    input  logic             dismiss_btn,
    output logic             alarm_start,
    output logic             alarm_stop,
    output logic             ringing,
    output logic [CNT_W-1:0] remaining,
    output logic [SCW-1:0]   snooze_cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] RING_LAST  = CNT_W'(RING_MAX_SEC - 1);
    localparam logic [CNT_W-1:0] SNOOZE_VAL = CNT_W'(SNOOZE_SEC);
    localparam logic [SCW-1:0]   SNZ_MAX    = SCW'(MAX_SNOOZE);

    nap_state_t       r_state;
    nap_state_t       w_nxt;
    logic             w_done;
    logic             w_tick;
    logic             w_clr;
    logic             w_timeout;
    logic             w_snz_ok;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_ring_sec;
    logic [SCW-1:0]   r_snooze_cnt;
    logic             r_alarm_start;
    logic             r_alarm_stop;
    logic             r_ringing;
    logic             r_done;

    assign w_clr = (w_nxt != r_state);

    nap_sec_ticker #(.TICK_DIV(TICK_DIV)) u_ticker (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_clr   (w_clr),
        .o_tick  (w_tick)
    );

    assign w_timeout = w_tick && (r_ring_sec == RING_LAST);
    assign w_snz_ok  = (r_snooze_cnt < SNZ_MAX);

    // An exhausted snooze press is ignored, so a same-cycle timeout still applies.
    always_comb begin
        w_nxt  = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (arm && (nap_sec != '0)) w_nxt = S_COUNT;
            end
            S_COUNT, S_SNOOZE: begin
                if (cancel)                                 w_nxt = S_IDLE;
                else if (w_tick && (r_remaining == CNT_W'(1))) w_nxt = S_RING;
            end
            S_RING: begin
                if (cancel) begin
                    w_nxt = S_IDLE;
                end else if (dismiss_btn) begin
                    w_nxt  = S_IDLE;
                    w_done = 1'b1;
                end else if ((snooze_btn || w_timeout) && w_snz_ok) begin
                    w_nxt = S_SNOOZE;
                end else if (w_timeout) begin
                    w_nxt  = S_IDLE;
                    w_done = 1'b1;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_remaining   <= '0;
            r_ring_sec    <= '0;
            r_snooze_cnt  <= '0;
            r_alarm_start <= 1'b0;
            r_alarm_stop  <= 1'b1;
            r_ringing     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_nxt;
            r_alarm_start <= (w_nxt == S_RING) && (r_state != S_RING);
            r_alarm_stop  <= (w_nxt != S_RING);
            r_ringing     <= (w_nxt == S_RING);
            r_done        <= w_done;

            case (r_state)
                S_IDLE: begin
                    if (w_nxt == S_COUNT) begin
                        r_remaining  <= nap_sec;
                        r_snooze_cnt <= '0;
                    end
                end
                S_COUNT, S_SNOOZE: begin
                    if (w_nxt != r_state)  r_remaining <= '0;
                    else if (w_tick)       r_remaining <= r_remaining - CNT_W'(1);
                end
                S_RING: begin
                    if (w_tick) r_ring_sec <= r_ring_sec + CNT_W'(1);
                    if (w_nxt == S_SNOOZE) begin
                        r_remaining  <= SNOOZE_VAL;
                        r_snooze_cnt <= r_snooze_cnt + SCW'(1);
                    end
                end
                default: r_remaining <= '0;
            endcase

            if ((w_nxt == S_RING) && (r_state != S_RING)) r_ring_sec <= '0;
        end
    end

    assign alarm_start = r_alarm_start;
    assign alarm_stop  = r_alarm_stop;
    assign ringing     = r_ringing;
    assign remaining   = r_remaining;
    assign snooze_cnt  = r_snooze_cnt;
    assign done        = r_done;

endmodule

// File: tb/tb_nap_scheduler.sv
// Directed bench for nap_scheduler with shortened timing constants.
module tb_nap_scheduler;

    localparam int CNT_W = 16;
    localparam int SCW   = 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             arm;
    logic [CNT_W-1:0] nap_sec;
    logic             cancel;
    logic             snooze_btn;
    logic             dismiss_btn;
    logic             alarm_start;
    logic             alarm_stop;
    logic             ringing;
    logic [CNT_W-1:0] remaining;
    logic [SCW-1:0]   snooze_cnt;
    logic             done;

    int errors = 0;
    int checks = 0;
    logic seen_start;

    always #5 clock = ~clock;

    nap_scheduler #(
        .TICK_DIV     (4),
        .CNT_W        (CNT_W),
        .SNOOZE_SEC   (2),
        .RING_MAX_SEC (3),
        .MAX_SNOOZE   (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .arm         (arm),
        .nap_sec     (nap_sec),
        .cancel      (cancel),
        .snooze_btn  (snooze_btn),
        .dismiss_btn (dismiss_btn),
        .alarm_start (alarm_start),
        .alarm_stop  (alarm_stop),
        .ringing     (ringing),
        .remaining   (remaining),
        .snooze_cnt  (snooze_cnt),
        .done        (done)
    );

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; arm = 1'b0; nap_sec = '0; cancel = 1'b0;
        snooze_btn = 1'b0; dismiss_btn = 1'b0;
        cyc(2);
        chk("rst_stop",   32'(alarm_stop), 1);
        chk("rst_start",  32'(alarm_start), 0);
        chk("rst_ring",   32'(ringing), 0);
        chk("rst_rem",    32'(remaining), 0);
        chk("rst_snz",    32'(snooze_cnt), 0);
        chk("rst_done",   32'(done), 0);
        reset = 1'b1;
        cyc(1);

        // 1: nap of 3 s rings 12 cycles after arm
        nap_sec = 16'd3; arm = 1'b1; cyc(1); arm = 1'b0;
        chk("t1_rem_load", 32'(remaining), 3);
        cyc(11);
        chk("t1_rem_last", 32'(remaining), 1);
        chk("t1_not_yet",  32'(ringing), 0);
        chk("t1_stop_hi",  32'(alarm_stop), 1);
        cyc(1);
        chk("t1_ring",     32'(ringing), 1);
        chk("t1_start",    32'(alarm_start), 1);
        chk("t1_stop_lo",  32'(alarm_stop), 0);
        chk("t1_rem_ring", 32'(remaining), 0);
        cyc(1);
        chk("t1_start_1c", 32'(alarm_start), 0);

        // 2: dismiss
        dismiss_btn = 1'b1; cyc(1); dismiss_btn = 1'b0;
        chk("t2_ring",  32'(ringing), 0);
        chk("t2_done",  32'(done), 1);
        chk("t2_stop",  32'(alarm_stop), 1);
        chk("t2_rem",   32'(remaining), 0);
        cyc(1);
        chk("t2_done_1c", 32'(done), 0);

        // 3: snooze, re-ring after 8 cycles, second snooze ignored
        nap_sec = 16'd1; arm = 1'b1; cyc(1); arm = 1'b0;
        cyc(4);
        chk("t3_ring1", 32'(ringing), 1);
        snooze_btn = 1'b1; cyc(1); snooze_btn = 1'b0;
        chk("t3_snz_ring", 32'(ringing), 0);
        chk("t3_snz_rem",  32'(remaining), 2);
        chk("t3_snz_cnt",  32'(snooze_cnt), 1);
        chk("t3_snz_stop", 32'(alarm_stop), 1);
        cyc(7);
        chk("t3_pre_ring", 32'(ringing), 0);
        cyc(1);
        chk("t3_ring2",    32'(ringing), 1);
        chk("t3_start2",   32'(alarm_start), 1);
        snooze_btn = 1'b1; cyc(1); snooze_btn = 1'b0;
        chk("t3_snz_ign",  32'(ringing), 1);
        chk("t3_snz_cnt2", 32'(snooze_cnt), 1);

        // 4a: exhausted timeout 12 cycles after ring entry
        cyc(10);
        chk("t4_still",  32'(ringing), 1);
        chk("t4_nodone", 32'(done), 0);
        cyc(1);
        chk("t4_to_ring", 32'(ringing), 0);
        chk("t4_to_done", 32'(done), 1);
        chk("t4_to_stop", 32'(alarm_stop), 1);

        // 4b: timeout with snoozes left goes to SNOOZE, then cancel there
        nap_sec = 16'd1; arm = 1'b1; cyc(1); arm = 1'b0;
        chk("t4b_cnt0", 32'(snooze_cnt), 0);
        cyc(4);
        chk("t4b_ring", 32'(ringing), 1);
        cyc(12);
        chk("t4b_ring_off", 32'(ringing), 0);
        chk("t4b_rem",      32'(remaining), 2);
        chk("t4b_cnt",      32'(snooze_cnt), 1);
        chk("t4b_nodone",   32'(done), 0);
        cancel = 1'b1; cyc(1); cancel = 1'b0;
        chk("t4b_cxl_rem",  32'(remaining), 0);
        chk("t4b_cxl_done", 32'(done), 0);

        // 5: cancel on the expiry tick, then arm with zero length
        nap_sec = 16'd1; arm = 1'b1; cyc(1); arm = 1'b0;
        cyc(3);
        cancel = 1'b1; cyc(1); cancel = 1'b0;
        chk("t5_cxl_ring",  32'(ringing), 0);
        chk("t5_cxl_rem",   32'(remaining), 0);
        seen_start = alarm_start;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            seen_start = seen_start | alarm_start;
        end
        chk("t5_no_start", 32'(seen_start), 0);
        nap_sec = 16'd0; arm = 1'b1; cyc(1); arm = 1'b0;
        chk("t5_zero_rem", 32'(remaining), 0);
        cyc(6);
        chk("t5_zero_ring", 32'(ringing), 0);

        // 6: re-arm and buttons during COUNT ignored, then reset mid-ring
        nap_sec = 16'd5; arm = 1'b1; cyc(1); arm = 1'b0;
        chk("t6_load", 32'(remaining), 5);
        cyc(5);
        chk("t6_dec", 32'(remaining), 4);
        nap_sec = 16'd9; arm = 1'b1; dismiss_btn = 1'b1; cyc(1);
        arm = 1'b0; dismiss_btn = 1'b0;
        chk("t6_no_reload", 32'(remaining), 4);
        chk("t6_no_done",   32'(done), 0);
        cyc(14);
        chk("t6_ring", 32'(ringing), 1);
        snooze_btn = 1'b1; cyc(1); snooze_btn = 1'b0;
        cyc(8);
        chk("t6_ring2",   32'(ringing), 1);
        chk("t6_cnt_pre", 32'(snooze_cnt), 1);
        reset = 1'b0; cyc(1);
        chk("t6_rst_stop", 32'(alarm_stop), 1);
        chk("t6_rst_ring", 32'(ringing), 0);
        chk("t6_rst_cnt",  32'(snooze_cnt), 0);
        reset = 1'b1;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
